// File: rtl/gray_arb_pkg.sv
// Shared types and defaults for the two-port gray-memory read arbiter.
// Holds the arbiter state encoding, default widths and small helpers.
package gray_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } arb_state_e;

  localparam int ADDR_W_DEF   = 14;
  localparam int DATA_W_DEF   = 8;
  localparam int MAX_HOLD_DEF = 16;
  localparam int HOLD_W       = 8;
  localparam int CNT_W        = 16;

  // Map a requester index to its grant state.
  function automatic arb_state_e grant_of(input logic sel);
    return sel ? G1 : G0;
  endfunction

endpackage

// File: rtl/arb_hold_cnt.sv
// Consecutive-grant hold counter: clears on clr, counts on inc, and stops at limit.
// at_limit tells the arbiter that the current owner has used its full slot.
module arb_hold_cnt
  import gray_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  input  logic [HOLD_W-1:0] limit,
  output logic              at_limit
);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == limit);

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !at_limit)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignment keeps every register updating from pre-edge values.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gray_port_arb.sv
// Two-requester arbiter for a single-port gray memory with bounded hold and fair pointer.
// Define GRAY_ARB_STATS_EN to enable the saturating cnt0/cnt1 grant-cycle counters.
module gray_port_arb
  import gray_arb_pkg::*;
#(
  parameter int addrWidth = ADDR_W_DEF,
  parameter int dataWidth = DATA_W_DEF,
  parameter int MAX_HOLD  = MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [addrWidth-1:0] addr0,
  input  logic                 req1,
  input  logic [addrWidth-1:0] addr1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 vld0,
  output logic                 vld1,
  output logic [dataWidth-1:0] data_out,
  input  logic                 gray_ready,
  output logic [addrWidth-1:0] gray_addr,
  output logic                 gray_req,
  input  logic [dataWidth-1:0] gray_data,
  output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]     cnt1
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

  arb_state_e state_q, state_d;
  logic       ptr_q, ptr_d;   // 0 favours requester 0, 1 favours requester 1
  logic       at_limit, hold_clr, hold_inc;

  always_comb begin
    state_d = state_q;
    if (!gray_ready) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 && req1) state_d = grant_of(ptr_q);
          else if (req0)    state_d = G0;
          else if (req1)    state_d = G1;
        end
        G0: begin
          if (!req0)                state_d = req1 ? G1 : IDLE;
          else if (req1 && at_limit) state_d = G1;
        end
        G1: begin
          if (!req1)                state_d = req0 ? G0 : IDLE;
          else if (req0 && at_limit) state_d = G0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Each new grant hands priority to the requester that was not just served.
  always_comb begin
    ptr_d = ptr_q;
    if (state_d != state_q) begin
      if (state_d == G0)      ptr_d = 1'b1;
      else if (state_d == G1) ptr_d = 1'b0;
    end
  end

  assign hold_clr = !gray_ready || (state_d != state_q);
  assign hold_inc = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  arb_hold_cnt u_hold (
    .clk      (clk),
    .reset    (reset),
    .clr      (hold_clr),
    .inc      (hold_inc),
    .limit    (HOLD_LIMIT),
    .at_limit (at_limit)
  );

  assign gnt0     = (state_q == G0);
  assign gnt1     = (state_q == G1);
  assign vld0     = gnt0 & req0;
  assign vld1     = gnt1 & req1;
  assign gray_req = gnt0 | gnt1;
  assign data_out = gray_data;

  always_comb begin
    gray_addr = '0;
    if (gnt0)      gray_addr = addr0;
    else if (gnt1) gray_addr = addr1;
  end

`ifdef GRAY_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (vld0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
      if (vld1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_gray_port_arb.sv
// Self-checking bench for gray_port_arb: directed scenarios plus randomized traffic
// compared against an owner/run-length reference model of the arbitration rules.
module tb_gray_port_arb;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int MH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, gray_ready;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] gray_data;
  logic          gnt0, gnt1, vld0, vld1, gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] data_out;
  logic [15:0]   cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the memory, how long they have held it, who is favoured.
  int          owner;
  int          run;
  int          fav;
  int unsigned m_cnt [2];

  gray_port_arb #(.addrWidth(AW), .dataWidth(DW), .MAX_HOLD(MH)) dut (
    .clk        (clk),
    .reset      (rst),
    .req0       (req0),
    .addr0      (addr0),
    .req1       (req1),
    .addr1      (addr1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .vld0       (vld0),
    .vld1       (vld1),
    .data_out   (data_out),
    .gray_ready (gray_ready),
    .gray_addr  (gray_addr),
    .gray_req   (gray_req),
    .gray_data  (gray_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner    = -1;
    run      = 0;
    fav      = 0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  function automatic logic [31:0] exp_cnt(input int idx);
`ifdef GRAY_ARB_STATS_EN
    return m_cnt[idx];
`else
    return (idx < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  // Advance the model by one clock edge using the inputs held during the cycle.
  task automatic model_step();
    int r [2];
    int nxt;
    r[0] = int'(req0);
    r[1] = int'(req1);
    if (owner >= 0 && r[owner] == 1 && m_cnt[owner] < 32'hFFFF) m_cnt[owner]++;
    if (!gray_ready)
      nxt = -1;
    else if (owner < 0)
      nxt = (r[0] == 1 && r[1] == 1) ? fav : (r[0] == 1) ? 0 : (r[1] == 1) ? 1 : -1;
    else if (r[owner] == 0)
      nxt = (r[1-owner] == 1) ? 1 - owner : -1;
    else if (r[1-owner] == 1 && run == MH - 1)
      nxt = 1 - owner;
    else
      nxt = owner;
    if (nxt == owner && owner >= 0) run = (run + 1 > MH - 1) ? MH - 1 : run + 1;
    else                            run = 0;
    if (nxt >= 0 && nxt != owner) fav = 1 - nxt;
    owner = nxt;
  endtask

  task automatic check_outputs();
    logic [AW-1:0] ea;
    ea = (owner == 0) ? addr0 : (owner == 1) ? addr1 : '0;
    check("gnt0", gnt0, owner == 0);
    check("gnt1", gnt1, owner == 1);
    check("vld0", vld0, owner == 0 && req0);
    check("vld1", vld1, owner == 1 && req1);
    check("gray_req", gray_req, owner >= 0);
    check("gray_addr", gray_addr, ea);
    check("data_out", data_out, gray_data);
    check("both_gnt", gnt0 & gnt1, 1'b0);
    check("cnt0", cnt0, exp_cnt(0));
    check("cnt1", cnt1, exp_cnt(1));
  endtask

  // Called just after a falling edge: drive, check, take the edge, return at next falling edge.
  task automatic run_cycle(input logic r0, input logic r1, input logic [AW-1:0] a0,
                           input logic [AW-1:0] a1, input logic rdy, input logic [DW-1:0] d);
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1; gray_ready = rdy; gray_data = d;
    #1 check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; gray_ready = 1'b0;
    addr0 = '0; addr1 = '0; gray_data = '0;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic r0, r1, rdy;

    // Reset state, then a lone requester 0 at address 129.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b1, 1'b0, 14'd129, 14'd7, 1'b1, 8'(i * 17));
      check("lone_gnt0", gnt0, 1'b1);
      check("lone_addr", gray_addr, 14'd129);
      check("lone_vld0", vld0, 1'b1);
    end

    // Both request from IDLE: G0 first, then 16-cycle alternation.
    do_reset();
    run_cycle(1'b1, 1'b1, 14'h0AA, 14'h155, 1'b1, 8'h3C);
    for (int i = 0; i < 3 * MH; i++) begin
      check("alt_gnt0", gnt0, ((i / MH) % 2) == 0);
      check("alt_gnt1", gnt1, ((i / MH) % 2) == 1);
      run_cycle(1'b1, 1'b1, 14'h0AA, 14'h155, 1'b1, 8'(i));
    end

    // Requester 0 drops mid-burst while requester 1 waits.
    do_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 14'h011, 14'h2AB, 1'b1, 8'h55);
    run_cycle(1'b0, 1'b1, 14'h011, 14'h2AB, 1'b1, 8'h66);
    check("drop_gnt1", gnt1, 1'b1);
    check("drop_gnt0", gnt0, 1'b0);
    check("drop_addr", gray_addr, 14'h2AB);
    run_cycle(1'b0, 1'b1, 14'h011, 14'h2AB, 1'b1, 8'h67);

    // Memory not ready during G1, then both request: requester 0 wins.
    do_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 14'h001, 14'h002, 1'b1, 8'h10);
    run_cycle(1'b1, 1'b1, 14'h001, 14'h002, 1'b0, 8'h11);
    check("nrdy_gnt0", gnt0, 1'b0);
    check("nrdy_gnt1", gnt1, 1'b0);
    run_cycle(1'b1, 1'b1, 14'h001, 14'h002, 1'b1, 8'h12);
    check("rerdy_gnt0", gnt0, 1'b1);
    run_cycle(1'b1, 1'b1, 14'h001, 14'h002, 1'b1, 8'h13);

    // Asynchronous reset pulse in the middle of a G0 burst.
    do_reset();
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b0, 14'h100, 14'h200, 1'b1, 8'h21);
    check("pre_rst_gnt0", gnt0, 1'b1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("async_gnt0", gnt0, 1'b0);
    check("async_req", gray_req, 1'b0);
    check("async_cnt0", cnt0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic with sticky requests so holds reach the limit.
    do_reset();
    r0 = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) r0 = ~r0;
      if ($urandom_range(0, 19) == 0) r1 = ~r1;
      rdy = ($urandom_range(0, 31) != 0);
      run_cycle(r0, r1, AW'($urandom), AW'($urandom), rdy, DW'($urandom));
    end

    // Long lone burst to exercise counter saturation.
    do_reset();
    for (int i = 0; i < 70000; i++)
      run_cycle(1'b1, 1'b0, AW'(i), 14'h0, 1'b1, DW'(i));
`ifdef GRAY_ARB_STATS_EN
    check("sat_cnt0", cnt0, 16'hFFFF);
`else
    check("sat_cnt0", cnt0, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
